// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for the bit-serial adder: latches an A/B/carry
// word, then streams it LSB first with per-bit framing flags.
module serial_operand_feeder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    input  logic             bit_en,
    input  logic             flush,
    output logic             a_bit,
    output logic             b_bit,
    output logic             c_init,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, a_nx;
    logic [WIDTH-1:0] b_sh, b_nx;
    logic             c_q, c_nx;
    logic [CW-1:0]    cnt, cnt_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            c_q   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            a_sh  <= a_nx;
            b_sh  <= b_nx;
            c_q   <= c_nx;
            cnt   <= cnt_nx;
        end
    end

    // Handshake: a pair transfers on the rising edge where in_valid && in_ready;
    // in_ready depends only on state, and the upstream may change a_in/b_in freely
    // while in_ready is low. Flush wins over both load and shift.
    always_comb begin
        state_nx = state;
        a_nx     = a_sh;
        b_nx     = b_sh;
        c_nx     = c_q;
        cnt_nx   = cnt;
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_nx     = a_in;
                        b_nx     = b_in;
                        c_nx     = cin_in;
                        cnt_nx   = '0;
                        state_nx = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        if (cnt == CNT_LAST) begin
                            state_nx = IDLE;
                        end else begin
                            a_nx   = {1'b0, a_sh[WIDTH-1:1]};
                            b_nx   = {1'b0, b_sh[WIDTH-1:1]};
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign bit_valid = (state == SHIFT);
    assign a_bit     = a_sh[0];
    assign b_bit     = b_sh[0];
    assign c_init    = c_q;
    assign first_bit = (state == SHIFT) && (cnt == '0);
    assign last_bit  = (state == SHIFT) && (cnt == CNT_LAST);
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: directed WIDTH=4 scenarios plus random word
// streams on WIDTH=2 and WIDTH=8 instances checked through an expected queue.
module tb_serial_operand_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       valid4, en4, flush4, cin4;
  logic [3:0] a4, b4;
  logic       ready4, abit4, bbit4, cinit4, bvalid4, fbit4, lbit4, dbg4;

  logic [1:0] s_valid, s_en, s_flush, s_cin;
  logic [7:0] s_a [2];
  logic [7:0] s_b [2];
  logic u2_ready, u2_abit, u2_bbit, u2_cinit, u2_bvalid, u2_fbit, u2_lbit, u2_dbg;
  logic u8_ready, u8_abit, u8_bbit, u8_cinit, u8_bvalid, u8_fbit, u8_lbit, u8_dbg;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  serial_operand_feeder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(valid4), .in_ready(ready4), .a_in(a4), .b_in(b4),
    .cin_in(cin4), .bit_en(en4), .flush(flush4), .a_bit(abit4), .b_bit(bbit4),
    .c_init(cinit4), .bit_valid(bvalid4), .first_bit(fbit4), .last_bit(lbit4),
    .state_dbg(dbg4)
  );

  serial_operand_feeder #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(s_valid[0]), .in_ready(u2_ready), .a_in(s_a[0][1:0]),
    .b_in(s_b[0][1:0]), .cin_in(s_cin[0]), .bit_en(s_en[0]), .flush(s_flush[0]),
    .a_bit(u2_abit), .b_bit(u2_bbit), .c_init(u2_cinit), .bit_valid(u2_bvalid),
    .first_bit(u2_fbit), .last_bit(u2_lbit), .state_dbg(u2_dbg)
  );

  serial_operand_feeder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(s_valid[1]), .in_ready(u8_ready), .a_in(s_a[1]),
    .b_in(s_b[1]), .cin_in(s_cin[1]), .bit_en(s_en[1]), .flush(s_flush[1]),
    .a_bit(u8_abit), .b_bit(u8_bbit), .c_init(u8_cinit), .bit_valid(u8_bvalid),
    .first_bit(u8_fbit), .last_bit(u8_lbit), .state_dbg(u8_dbg)
  );

  task automatic test_reset();
    rst = 1'b0;
    valid4 = 1'b0; en4 = 1'b0; flush4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    s_valid = '0; s_en = '0; s_flush = '0; s_cin = '0;
    s_a[0] = '0; s_a[1] = '0; s_b[0] = '0; s_b[1] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready4, bvalid4, fbit4, lbit4, abit4, bbit4, cinit4} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 1000000",
               {ready4, bvalid4, fbit4, lbit4, abit4, bbit4, cinit4});
    end
    checks++;
    if ({u2_ready, u2_bvalid, u8_ready, u8_bvalid} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_sweep_duts got %b want 1010", {u2_ready, u2_bvalid, u8_ready, u8_bvalid});
    end
    rst = 1'b1;
  endtask

  task automatic test_basic_word();
    logic [3:0] ea, eb;
    ea = 4'b1011; eb = 4'b0110;
    a4 = ea; b4 = eb; cin4 = 1'b1; valid4 = 1'b1; en4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bvalid4, ready4, abit4, bbit4, fbit4, lbit4, dbg4} !==
          {1'b1, 1'b0, ea[i], eb[i], (i == 0), (i == 3), 1'b1}) begin
        errors++;
        $display("FAIL basic_bit%0d got v%b r%b a%b b%b f%b l%b s%b want v1 r0 a%b b%b f%b l%b s1",
                 i, bvalid4, ready4, abit4, bbit4, fbit4, lbit4, dbg4, ea[i], eb[i], (i == 0), (i == 3));
      end
      if (i == 0) begin
        checks++;
        if (cinit4 !== 1'b1) begin
          errors++;
          $display("FAIL basic_c_init got %b want 1", cinit4);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({ready4, bvalid4} !== 2'b10) begin
      errors++;
      $display("FAIL basic_ready_after got r%b v%b want r1 v0", ready4, bvalid4);
    end
  endtask

  task automatic test_stall();
    logic [5:0] ea, eb, ef, el, en_t;
    ea = 6'b101111; eb = 6'b011110; ef = 6'b000001; el = 6'b100000; en_t = 6'b111001;
    a4 = 4'b1011; b4 = 4'b0110; cin4 = 1'b1; valid4 = 1'b1; en4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bvalid4, abit4, bbit4, fbit4, lbit4} !== {1'b1, ea[i], eb[i], ef[i], el[i]}) begin
        errors++;
        $display("FAIL stall_cycle%0d got v%b a%b b%b f%b l%b want v1 a%b b%b f%b l%b",
                 i, bvalid4, abit4, bbit4, fbit4, lbit4, ea[i], eb[i], ef[i], el[i]);
      end
      en4 = en_t[i];
      @(negedge clk);
    end
    checks++;
    if ({ready4, bvalid4} !== 2'b10) begin
      errors++;
      $display("FAIL stall_ready_after got r%b v%b want r1 v0", ready4, bvalid4);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acc_a, acc_b;
    logic       acc_c;
    logic [16:0] e;
    int idx, nf, nl, lcyc, fcyc;
    idx = 0; nf = 0; nl = 0; lcyc = -1; fcyc = -1;
    acc_a = '0; acc_b = '0; acc_c = 1'b0;
    a4 = 4'b1001; b4 = 4'b0011; cin4 = 1'b0; valid4 = 1'b1; en4 = 1'b1;
    exp_q.push_back({1'b0, 4'b0, 4'b0011, 4'b0, 4'b1001});
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin
        checks++;
        if ({ready4, bvalid4} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_idle_gap got r%b v%b want r1 v0", ready4, bvalid4);
        end
      end
      if (bvalid4 === 1'b1) begin
        if (fbit4 === 1'b1) begin
          idx = 0; nf++; acc_c = cinit4;
          if (lcyc >= 0) fcyc = cyc;
        end
        if (idx < 4) begin
          acc_a[idx] = abit4; acc_b[idx] = bbit4;
        end
        idx++;
        if (lbit4 === 1'b1) begin
          nl++;
          if (lcyc < 0) lcyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_word got a%b b%b want nothing queued", acc_a, acc_b);
          end else begin
            e = exp_q.pop_front();
            if ({acc_c, 4'b0, acc_b, 4'b0, acc_a} !== e) begin
              errors++;
              $display("FAIL b2b_word got %h want %h", {acc_c, 4'b0, acc_b, 4'b0, acc_a}, e);
            end
          end
        end
      end
      if (cyc <= 3) begin
        a4 = 4'(cyc * 3); b4 = ~a4; cin4 = cyc[0];
      end else if (cyc == 4) begin
        a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b0;
      end else if (cyc == 5) begin
        a4 = 4'b0110; b4 = 4'b1100; cin4 = 1'b1;
        exp_q.push_back({1'b1, 4'b0, 4'b1100, 4'b0, 4'b0110});
      end else begin
        valid4 = 1'b0;
      end
    end
    checks++;
    if (nf != 2 || nl != 2 || fcyc - lcyc != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_framing got first=%0d last=%0d gap=%0d left=%0d want 2 2 2 0",
               nf, nl, fcyc - lcyc, exp_q.size());
    end
  endtask

  task automatic test_flush();
    a4 = 4'b1011; b4 = 4'b0110; cin4 = 1'b1; valid4 = 1'b1; en4 = 1'b1; flush4 = 1'b0;
    @(negedge clk);
    valid4 = 1'b0;
    repeat (2) @(negedge clk);
    flush4 = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready4, bvalid4, fbit4, lbit4} !== 4'b1000) begin
      errors++;
      $display("FAIL flush_abort got r%b v%b f%b l%b want r1 v0 f0 l0", ready4, bvalid4, fbit4, lbit4);
    end
    flush4 = 1'b0; a4 = 4'b0101; b4 = 4'b1010; cin4 = 1'b0; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    checks++;
    if ({bvalid4, fbit4, abit4, bbit4, cinit4} !== 5'b11100) begin
      errors++;
      $display("FAIL flush_reload got v%b f%b a%b b%b c%b want v1 f1 a1 b0 c0",
               bvalid4, fbit4, abit4, bbit4, cinit4);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({lbit4, abit4, bbit4} !== 3'b101) begin
      errors++;
      $display("FAIL flush_reload_last got l%b a%b b%b want l1 a0 b1", lbit4, abit4, bbit4);
    end
    @(negedge clk);
    a4 = 4'b1111; valid4 = 1'b1; flush4 = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready4, bvalid4} !== 2'b10) begin
      errors++;
      $display("FAIL flush_blocks_load got r%b v%b want r1 v0", ready4, bvalid4);
    end
    valid4 = 1'b0; flush4 = 1'b0;
  endtask

  task automatic test_async_reset();
    a4 = 4'b1011; b4 = 4'b0110; cin4 = 1'b1; valid4 = 1'b1; en4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bvalid4, abit4, bbit4} !== 3'b111) begin
      errors++;
      $display("FAIL areset_pre got v%b a%b b%b want 111", bvalid4, abit4, bbit4);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ready4, bvalid4, fbit4, lbit4, abit4, bbit4, cinit4} !== 7'b1000000) begin
      errors++;
      $display("FAIL areset_immediate got %b want 1000000",
               {ready4, bvalid4, fbit4, lbit4, abit4, bbit4, cinit4});
    end
    @(negedge clk);
    rst = 1'b1; a4 = 4'b0011; b4 = 4'b0101; cin4 = 1'b1; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    checks++;
    if ({bvalid4, fbit4, abit4, bbit4, cinit4} !== 5'b11111) begin
      errors++;
      $display("FAIL areset_first_load got v%b f%b a%b b%b c%b want 11111",
               bvalid4, fbit4, abit4, bbit4, cinit4);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ready4 !== 1'b1) begin
      errors++;
      $display("FAIL areset_word_done got r%b want 1", ready4);
    end
  endtask

  task automatic test_sweep(input int k, input int w, input int nwords);
    logic [7:0] mask, av, bv, acc_a, acc_b;
    logic cv, acc_c, o_ready, o_abit, o_bbit, o_cinit, o_bvalid, o_fbit, o_lbit;
    logic [16:0] e;
    int idx, nf, nl, cyc;
    bit done;
    mask = 8'((1 << w) - 1);
    for (int n = 0; n < nwords; n++) begin
      av = 8'($urandom) & mask; bv = 8'($urandom) & mask; cv = 1'($urandom_range(0, 1));
      s_a[k] = av; s_b[k] = bv; s_cin[k] = cv; s_valid[k] = 1'b1; s_en[k] = 1'b1;
      exp_q.push_back({cv, bv, av});
      idx = 0; nf = 0; nl = 0; cyc = 0; done = 1'b0;
      acc_a = '0; acc_b = '0; acc_c = 1'b0;
      while (!done && cyc < 4 * w + 8) begin
        @(negedge clk);
        cyc++;
        s_valid[k] = 1'b0;
        s_en[k] = ($urandom_range(0, 3) != 0);
        o_abit   = (k == 0) ? u2_abit   : u8_abit;
        o_bbit   = (k == 0) ? u2_bbit   : u8_bbit;
        o_cinit  = (k == 0) ? u2_cinit  : u8_cinit;
        o_bvalid = (k == 0) ? u2_bvalid : u8_bvalid;
        o_fbit   = (k == 0) ? u2_fbit   : u8_fbit;
        o_lbit   = (k == 0) ? u2_lbit   : u8_lbit;
        if (o_bvalid === 1'b1 && s_en[k] === 1'b1) begin
          if (o_fbit === 1'b1) begin
            nf++; acc_c = o_cinit;
          end
          if (idx < 8) begin
            acc_a[idx] = o_abit; acc_b[idx] = o_bbit;
          end
          idx++;
          if (o_lbit === 1'b1) begin
            nl++; done = 1'b1;
          end
        end
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL sweep_w%0d_timeout got no last_bit in %0d cycles want one", w, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({acc_c, acc_b, acc_a} !== e || nf != 1 || nl != 1 || idx != w) begin
          errors++;
          $display("FAIL sweep_w%0d_word got %h first=%0d last=%0d bits=%0d want %h 1 1 %0d",
                   w, {acc_c, acc_b, acc_a}, nf, nl, idx, e, w);
        end
      end
      @(negedge clk);
      o_ready = (k == 0) ? u2_ready : u8_ready;
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL sweep_w%0d_ready got %b want 1", w, o_ready);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_sweep(0, 2, 20);
    test_sweep(1, 8, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_operand_feeder.md
# serial_operand_feeder

Upstream stage of the bit-serial adder. Accepts a pair of parallel operands plus an initial carry through a valid/ready handshake, then presents them to the serial adder one bit per enabled cycle, LSB first. Alongside each bit it supplies framing flags (`bit_valid`, `first_bit`, `last_bit`) so the adder's carry flop can be seeded and the downstream collector can delimit words. A downstream enable stalls the stream, and a synchronous flush aborts it.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range WIDTH >= 2.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset. `rst`=0 forces the reset state immediately.
- `in_valid` input 1: the operand pair on `a_in`/`b_in`/`cin_in` is valid.
- `in_ready` output 1: the block can accept an operand pair.
- `a_in` input WIDTH: operand A.
- `b_in` input WIDTH: operand B.
- `cin_in` input 1: carry-in for the word.
- `bit_en` input 1: downstream enable; the current bit is consumed on an edge with `bit_en`=1.
- `flush` input 1: synchronous abort; returns the block to IDLE.
- `a_bit` output 1: current bit of A.
- `b_bit` output 1: current bit of B.
- `c_init` output 1: latched `cin_in`; meaningful when `first_bit`=1.
- `bit_valid` output 1: `a_bit`/`b_bit` are valid.
- `first_bit` output 1: current bit is bit 0.
- `last_bit` output 1: current bit is bit WIDTH-1.

## Operation
- Internal state:
  - Two shift registers, `a_sh` and `b_sh`, each WIDTH bits.
  - Carry latch `c_q`.
  - Bit counter `cnt`, width $clog2(WIDTH). It counts 0..WIDTH-1 and never wraps past WIDTH-1.
  - Two-state FSM: IDLE, SHIFT.
- Outputs are combinational from state only, with no combinational path from any input:
  - `in_ready` = (state==IDLE).
  - `bit_valid` = (state==SHIFT).
  - `a_bit` = `a_sh[0]`, `b_bit` = `b_sh[0]`.
  - `first_bit` = SHIFT && `cnt`==0.
  - `last_bit` = SHIFT && `cnt`==WIDTH-1.
  - `c_init` = `c_q`.
- IDLE:
  - On an edge with `in_valid`=1: load `a_sh`<=`a_in`, `b_sh`<=`b_in`, `c_q`<=`cin_in`, `cnt`<=0; go to SHIFT.
  - `bit_en` is ignored in IDLE.
- SHIFT:
  - Edge with `bit_en`=0: hold all state; the outputs stay stable (stall).
  - Edge with `bit_en`=1 and `cnt`<WIDTH-1: shift `a_sh`/`b_sh` right by 1 (zero fill), `cnt`<=`cnt`+1.
  - Edge with `bit_en`=1 and `cnt`==WIDTH-1: go to IDLE. Shift registers are don't-care afterwards; `cnt` is held.
  - `in_valid` is ignored in SHIFT. No pair is accepted while `in_ready`=0.
- `flush`=1 on an edge:
  - Go to IDLE, `cnt`<=0. Shift registers and `c_q` hold.
  - `flush` has priority over both load and shift.
  - `flush` together with `in_valid` in IDLE: nothing is loaded.
- Reset (`rst`=0):
  - State IDLE, `cnt`=0, `a_sh`=`b_sh`=0, `c_q`=0.
  - Output values: `in_ready`=1, `bit_valid`=0, `first_bit`=0, `last_bit`=0, `a_bit`=0, `b_bit`=0, `c_init`=0.
  - Reset mid-word discards the word with no partial completion.

## Timing
- Acceptance occurs on the edge where `in_valid`&&`in_ready`. The first bit is visible in the cycle after that edge (latency 1).
- With `bit_en` held at 1, a word occupies WIDTH cycles in SHIFT. `in_ready` returns in the cycle after the `last_bit` edge.
- Peak throughput is one word per WIDTH+1 cycles; there is no back-to-back overlap.
- Each stall cycle adds exactly one cycle to the word. Bit order and flags are unchanged by stalls.
- `first_bit` and `last_bit` are never both 1, because WIDTH >= 2.
- Release of `rst` is sampled asynchronously. The first load can occur on the first edge after release.

## Test plan
- **Basic word.** WIDTH=4, `rst` pulse, then `a_in`=4'b1011, `b_in`=4'b0110, `cin_in`=1, `in_valid` for 1 cycle, `bit_en`=1.
  - Required: `a_bit` sequence 1,1,0,1 and `b_bit` sequence 0,1,1,0 over 4 cycles.
  - Required: `first_bit` on cycle 1 with `c_init`=1; `last_bit` on cycle 4; `in_ready`=1 on cycle 5.
- **Stall.** Same operands, `bit_en`=0 for 2 cycles while `cnt`==1.
  - Required: `a_bit`=1, `b_bit`=1 held for 3 cycles; word completes in 6 cycles with the sequence unchanged.
- **Back-to-back requests.** `in_valid` held high across a word with `a_in` changed mid-word.
  - Required: the mid-word value is ignored; the second pair is accepted only on the first IDLE edge.
  - Required: exactly 1 idle cycle between the two `last_bit` and `first_bit` pulses.
- **Flush.** `flush`=1 while `cnt`==2.
  - Required: next cycle `bit_valid`=0, `in_ready`=1; a new load then starts with `first_bit`=1.
  - Also: `flush`+`in_valid` in IDLE results in no load.
- **Async reset.** `rst`=0 mid-edge-period while in SHIFT.
  - Required: `bit_valid`, `first_bit`, `last_bit`, `a_bit`, `b_bit` go to 0 and `in_ready` to 1 immediately, before the next `clk` edge.
- **Parameter sweep.** Repeat random operand pairs for WIDTH=2 and WIDTH=8.
  - Required: a scoreboard reconstructs `a_in`/`b_in` exactly from the bit streams.
  - Required: exactly one `first_bit` and one `last_bit` per word.
